flash_rd: RTL and testbench

FLASH_RD -- requirements
Module: flash_rd

---
 rtl/flash_rd.sv | 138 +++++++++++++
 tb/tb_flash_rd.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_rd.sv
// SPI flash reader: issues 0x03 + 24-bit address, then clocks in RD_LEN bytes.
// SPI mode 0, MSB first, programmable SCK half-period.
module flash_rd #(
  parameter int SCK_HALF = 2,
  parameter int RD_LEN   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_start,
  input  logic [23:0] rd_addr,
  input  logic        miso,
  output logic        flash_rd_busy,
  output logic        cs_n_rd,
  output logic        sck_rd,
  output logic        mosi_rd,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_done
);

  localparam int NBITS = 32 + 8 * RD_LEN;
  localparam int BW    = 14;
  localparam int PW    = 9;

  localparam logic [PW-1:0] PH_SET  = PW'(SCK_HALF - 1);
  localparam logic [PW-1:0] PH_HIGH = PW'(SCK_HALF);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * SCK_HALF - 1);
  localparam logic [BW-1:0] B_DATA  = BW'(32);
  localparam logic [BW-1:0] B_LAST  = BW'(NBITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [31:0]   tx_q, tx_d;
  logic [6:0]    rx_q, rx_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_start) begin
          state_d = CS_SETUP;
          tx_d    = {8'h03, rd_addr};
          ph_d    = '0;
          bit_d   = '0;
        end
      end
      CS_SETUP: begin
        if (ph_q == PH_SET) begin
          state_d = SHIFT;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      SHIFT: begin
        if (ph_q == PH_LAST) begin
          // End of high half: sample, and advance mosi for the next bit
          ph_d  = '0;
          tx_d  = {tx_q[30:0], 1'b0};
          bit_d = bit_q + 1'b1;
          if (bit_q >= B_DATA) begin
            rx_d = {rx_q[5:0], miso};
            if (bit_q[2:0] == 3'd7) begin
              data_d  = {rx_q, miso};
              valid_d = 1'b1;
            end
          end
          if (bit_q == B_LAST) begin
            state_d = CS_HOLD;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      CS_HOLD: begin
        if (ph_q == PH_SET) begin
          state_d = DONE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign flash_rd_busy = (state_q != IDLE);
  assign cs_n_rd       = (state_q == IDLE) || (state_q == DONE);
  assign sck_rd        = (state_q == SHIFT) && (ph_q >= PH_HIGH);
  assign mosi_rd       = ((state_q == CS_SETUP) || (state_q == SHIFT))
                         && tx_q[31];
  assign rd_data       = data_q;
  assign rd_valid      = valid_q;
  assign rd_done       = (state_q == DONE);

endmodule

// File: tb/tb_flash_rd.sv
// Bench for flash_rd: behavioural flash slave plus cycle-level transaction
// bookkeeping, compared against timing and data derived from bit counts.
module tb_flash_rd;

  localparam int SH0 = 2;
  localparam int RL0 = 2;
  localparam int SH1 = 1;
  localparam int RL1 = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  start = '0;
  logic [23:0] addr [2];
  logic [1:0]  miso_r = '0;
  logic [1:0]  busy, csn, sck, mosi, valid, done;
  logic [7:0]  data [2];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int t0 [2];
  int busy_rise [2];
  int busy_fall [2];
  int first_rise [2];
  int done_cyc [2];
  int n_done [2];
  int n_rise [2];
  int n_valid [2];
  int n_brise [2];
  int viol [2];
  int csbad [2];
  logic [31:0] cmd [2];
  logic [7:0] fdata [2][16];
  logic [7:0] vb [2][16];
  logic [1:0] pbusy = '0;
  logic [1:0] psck = '0;
  logic [1:0] pmosi = '0;
  logic [13:0] snap;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  flash_rd #(.SCK_HALF(SH0), .RD_LEN(RL0)) u0 (
    .clk(clk), .rst_n(rst_n), .rd_start(start[0]), .rd_addr(addr[0]),
    .miso(miso_r[0]), .flash_rd_busy(busy[0]), .cs_n_rd(csn[0]),
    .sck_rd(sck[0]), .mosi_rd(mosi[0]), .rd_data(data[0]),
    .rd_valid(valid[0]), .rd_done(done[0])
  );

  flash_rd #(.SCK_HALF(SH1), .RD_LEN(RL1)) u1 (
    .clk(clk), .rst_n(rst_n), .rd_start(start[1]), .rd_addr(addr[1]),
    .miso(miso_r[1]), .flash_rd_busy(busy[1]), .cs_n_rd(csn[1]),
    .sck_rd(sck[1]), .mosi_rd(mosi[1]), .rd_data(data[1]),
    .rd_valid(valid[1]), .rd_done(done[1])
  );

  function automatic int exp_fall(input int sh, input int rl);
    return 1 + 2 * sh + 2 * sh * (32 + 8 * rl) + 1;
  endfunction

  task automatic clr(input int k);
    busy_rise[k] = -1;
    busy_fall[k] = -1;
    first_rise[k] = -1;
    done_cyc[k] = -1;
    n_done[k] = 0;
    n_rise[k] = 0;
    n_valid[k] = 0;
    n_brise[k] = 0;
    viol[k] = 0;
    csbad[k] = 0;
    cmd[k] = '0;
  endtask

  // Flash slave + observer, sampled mid-cycle
  task automatic observe(input int k);
    int rel;
    int n;
    rel = cyc - t0[k];
    if (busy[k] && !pbusy[k]) begin
      busy_rise[k] = rel;
      n_brise[k]++;
    end
    if (!busy[k] && pbusy[k]) busy_fall[k] = rel;
    if (sck[k] && !psck[k]) begin
      if (n_rise[k] == 0) first_rise[k] = rel;
      if (n_rise[k] < 32) begin
        cmd[k] = {cmd[k][30:0], mosi[k]};
      end else begin
        if (mosi[k]) viol[k]++;
        n = n_rise[k] - 32;
        if (n < 128) miso_r[k] = fdata[k][n / 8][7 - (n % 8)];
      end
      n_rise[k]++;
    end
    if (busy[k] && (mosi[k] != pmosi[k]) && !(psck[k] && !sck[k])
        && pbusy[k])
      viol[k]++;
    if (valid[k]) begin
      if (n_valid[k] < 16) vb[k][n_valid[k]] = data[k];
      n_valid[k]++;
    end
    if (done[k]) begin
      n_done[k]++;
      done_cyc[k] = rel;
      if (!csn[k] || !busy[k]) csbad[k]++;
    end else if (busy[k] == csn[k]) begin
      csbad[k]++;
    end
    pbusy[k] = busy[k];
    psck[k] = sck[k];
    pmosi[k] = mosi[k];
  endtask

  always @(negedge clk) begin
    observe(0);
    observe(1);
  end

  task automatic run_txn(input int k, input logic [23:0] a,
                         input int p1, input int p2, input int rst_at);
    int rel;
    bit fin;
    clr(k);
    fin = 0;
    @(posedge clk);
    #1;
    t0[k] = cyc;
    addr[k] = a;
    start[k] = 1'b1;
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(posedge clk);
      #1;
      rel = cyc - t0[k];
      if (rel == rst_at + 1)
        snap = {busy[0], csn[0], sck[0], mosi[0], data[0], valid[0], done[0]};
      rst_n = (rel != rst_at);
      start[k] = (rel == p1) || (rel == p2);
      if (busy_fall[k] >= 0 && rel >= busy_fall[k] + 8) fin = 1;
    end
    start[k] = 1'b0;
    rst_n = 1'b1;
    n_chk++;
    if (!fin) begin
      n_fail++;
      $display("FAIL timeout dut%0d: busy never fell within 3000 cycles", k);
    end
  endtask

  task automatic load_random(input int k);
    for (int j = 0; j < 16; j++) fdata[k][j] = 8'($urandom_range(0, 255));
  endtask

  task automatic check_data(input int k, input logic [23:0] a,
                            input int rl, input string nm);
    n_chk++;
    if (cmd[k] !== {8'h03, a}) begin
      n_fail++;
      $display("FAIL %s cmd: got %h want %h", nm, cmd[k], {8'h03, a});
    end
    n_chk++;
    if (n_valid[k] !== rl) begin
      n_fail++;
      $display("FAIL %s n_valid: got %0d want %0d", nm, n_valid[k], rl);
    end
    for (int j = 0; j < rl; j++) begin
      n_chk++;
      if (vb[k][j] !== fdata[k][j]) begin
        n_fail++;
        $display("FAIL %s byte%0d: got %h want %h", nm, j, vb[k][j],
                 fdata[k][j]);
      end
    end
    n_chk++;
    if (viol[k] !== 0 || csbad[k] !== 0) begin
      n_fail++;
      $display("FAIL %s bus: mosi_viol %0d cs_bad %0d want 0 0", nm,
               viol[k], csbad[k]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if ({busy[k], csn[k], sck[k], mosi[k], data[k], valid[k], done[k]}
          !== 14'b0100_0000_0000_00) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %b want 01000000000000", k,
                 {busy[k], csn[k], sck[k], mosi[k], data[k], valid[k],
                  done[k]});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    fdata[0][0] = 8'hA5;
    fdata[0][1] = 8'h3C;
    run_txn(0, 24'h123456, 50, exp_fall(SH0, RL0) - 1, -10);
    n_chk++;
    if (busy_rise[0] !== 1 || first_rise[0] !== 1 + 2 * SH0) begin
      n_fail++;
      $display("FAIL basic start: busy_rise %0d sck_rise %0d want 1 %0d",
               busy_rise[0], first_rise[0], 1 + 2 * SH0);
    end
    n_chk++;
    if (done_cyc[0] !== exp_fall(SH0, RL0) - 1) begin
      n_fail++;
      $display("FAIL basic done_cyc: got %0d want %0d", done_cyc[0],
               exp_fall(SH0, RL0) - 1);
    end
    n_chk++;
    if (busy_fall[0] !== exp_fall(SH0, RL0)) begin
      n_fail++;
      $display("FAIL basic busy_fall: got %0d want %0d", busy_fall[0],
               exp_fall(SH0, RL0));
    end
    n_chk++;
    if (n_done[0] !== 1 || n_brise[0] !== 1) begin
      n_fail++;
      $display("FAIL basic ignore_start: dones %0d txns %0d want 1 1",
               n_done[0], n_brise[0]);
    end
    n_chk++;
    if (n_rise[0] !== 32 + 8 * RL0) begin
      n_fail++;
      $display("FAIL basic sck_rises: got %0d want %0d", n_rise[0],
               32 + 8 * RL0);
    end
    check_data(0, 24'h123456, RL0, "basic");
  endtask

  task automatic test_random;
    logic [23:0] a;
    for (int r = 0; r < 3; r++) begin
      load_random(0);
      a = 24'($urandom);
      run_txn(0, a, -10, -10, -10);
      n_chk++;
      if (busy_fall[0] - busy_rise[0] !== exp_fall(SH0, RL0) - 1) begin
        n_fail++;
        $display("FAIL random width: got %0d want %0d",
                 busy_fall[0] - busy_rise[0], exp_fall(SH0, RL0) - 1);
      end
      check_data(0, a, RL0, "random");
    end
  endtask

  task automatic test_reset_mid;
    logic [23:0] a;
    load_random(0);
    run_txn(0, 24'hABCDEF, -10, -10, 100);
    n_chk++;
    if (snap !== 14'b0100_0000_0000_00) begin
      n_fail++;
      $display("FAIL midreset outputs: got %b want 01000000000000", snap);
    end
    n_chk++;
    if (n_done[0] !== 0 || n_valid[0] !== 0 || busy_fall[0] !== 101) begin
      n_fail++;
      $display("FAIL midreset strobes: done %0d valid %0d fall %0d want 0 0 101",
               n_done[0], n_valid[0], busy_fall[0]);
    end
    load_random(0);
    a = 24'($urandom);
    run_txn(0, a, -10, -10, -10);
    n_chk++;
    if (busy_fall[0] !== exp_fall(SH0, RL0) || n_done[0] !== 1) begin
      n_fail++;
      $display("FAIL midreset rerun: fall %0d dones %0d want %0d 1",
               busy_fall[0], n_done[0], exp_fall(SH0, RL0));
    end
    check_data(0, a, RL0, "rerun");
  endtask

  task automatic test_fast;
    logic [23:0] a;
    load_random(1);
    a = 24'($urandom);
    run_txn(1, a, -10, -10, -10);
    n_chk++;
    if (n_rise[1] !== 40 || first_rise[1] !== 1 + 2 * SH1) begin
      n_fail++;
      $display("FAIL fast sck: rises %0d first %0d want 40 %0d",
               n_rise[1], first_rise[1], 1 + 2 * SH1);
    end
    n_chk++;
    if (busy_fall[1] - busy_rise[1] !== 83) begin
      n_fail++;
      $display("FAIL fast width: got %0d want 83",
               busy_fall[1] - busy_rise[1]);
    end
    check_data(1, a, RL1, "fast");
  endtask

  initial begin
    addr[0] = '0;
    addr[1] = '0;
    t0[0] = 0;
    t0[1] = 0;
    clr(0);
    clr(1);
    test_reset();
    test_basic();
    test_random();
    test_reset_mid();
    test_fast();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
